// File: rtl/rmsnorm_result_packer.sv
// -----------------------------------------------------------------------------
// rmsnorm_result_packer
//
// Output end of the RMSNORM result stream. Each 128-bit input beat holds four
// fp32 lanes. Every lane is rounded to bf16 (round-to-nearest-even) and the four
// bf16 values are packed into one 64-bit word, in the same lane layout RMSNORM
// consumes on its input. The upstream source cannot be stalled, so a small
// first-word-fall-through FIFO decouples it from a ready/valid sink. Beats that
// arrive while the FIFO is full are dropped and flagged with a sticky overflow.
// Every row of DATA_NUM beats is framed with m_tlast on its final word.
//
// Ports
//   clk          in   1    single clock, rising edge
//   rst_n        in   1    asynchronous active-low reset
//   stage_start  in   1    stage enable; its rising edge clears all state
//   in_tvalid    in   1    input beat valid (no ready: beat is taken or dropped)
//   in_tdata     in   128  lane k = in_tdata[32k+31:32k], fp32
//   m_tvalid     out  1    output word valid (FIFO not empty)
//   m_tready     in   1    downstream ready
//   m_tdata      out  64   lane k = m_tdata[16k+15:16k], bf16
//   m_tlast      out  1    last word of a row
//   overflow     out  1    sticky: a beat was dropped because the FIFO was full
//   row_done     out  1    1-cycle pulse after the tlast word is accepted
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rmsnorm_result_packer #(
    parameter int DATA_NUM   = 192,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stage_start,
    input  logic         in_tvalid,
    input  logic [127:0] in_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [63:0]  m_tdata,
    output logic         m_tlast,
    output logic         overflow,
    output logic         row_done
);

    localparam int                CNT_W    = $clog2(DATA_NUM);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DATA_NUM - 1);
    localparam int                ENTRY_W  = 65;  // {tlast, 4 x bf16}

    // -------------------------------------------------------------------------
    // fp32 -> bf16, round-to-nearest-even.
    // Adding 0x7FFF plus the lowest kept bit rounds the discarded half up on
    // ties only when the kept value is odd. A carry out of the mantissa rolls
    // into the exponent, so the largest finite values correctly become inf.
    // NaNs are made quiet and canonical so rounding can never turn one into inf.
    // -------------------------------------------------------------------------
    function automatic logic [15:0] fp32_to_bf16(input logic [31:0] f);
        logic [31:0] rounded;
        rounded = f + 32'h0000_7FFF + {31'd0, f[16]};
        if ((f[30:23] == 8'hFF) && (f[22:0] != 23'd0)) begin
            return {f[31], 15'h7FC0};
        end
        return rounded[31:16];
    endfunction

    // -------------------------------------------------------------------------
    // Clear detection: only the rising edge of stage_start clears, so holding
    // stage_start high for the whole stage does not keep the block in clear.
    // -------------------------------------------------------------------------
    logic stage_start_q;
    logic clear;

    assign clear = stage_start & ~stage_start_q;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_start_q <= 1'b0;
        end else begin
            stage_start_q <= stage_start;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: convert and register one beat, tag it with its row position.
    // The row counter advances on every accepted input beat, including beats
    // later dropped at the FIFO, so framing never drifts after an overflow.
    // -------------------------------------------------------------------------
    logic             s1_valid;
    logic [63:0]      s1_data;
    logic             s1_last;
    logic [CNT_W-1:0] row_cnt;
    logic [63:0]      conv_data;

    always_comb begin
        conv_data = '0;
        for (int k = 0; k < 4; k++) begin
            conv_data[16*k +: 16] = fp32_to_bf16(in_tdata[32*k +: 32]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_last  <= 1'b0;
            row_cnt  <= '0;
        end else if (clear) begin
            // Input is ignored in the clear cycle.
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            row_cnt  <= '0;
        end else begin
            s1_valid <= in_tvalid;
            if (in_tvalid) begin
                s1_data <= conv_data;
                s1_last <= (row_cnt == LAST_IDX);
                row_cnt <= (row_cnt == LAST_IDX) ? '0 : row_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: first-word-fall-through FIFO.
    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // with all FIFO_DEPTH entries in use.
    // -------------------------------------------------------------------------
    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W:0]    wr_ptr;
    logic [ADDR_W:0]    rd_ptr;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               drop;
    logic [ENTRY_W-1:0] head;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                        (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

    // A full FIFO still accepts a word when the head leaves in the same cycle.
    // Pop needs a non-empty FIFO, so an empty FIFO never forwards a word
    // combinationally: a pushed word appears at the output one edge later.
    assign pop  = m_tvalid & m_tready;
    assign push = s1_valid & (~fifo_full | pop);
    assign drop = s1_valid & fifo_full & ~pop;

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are meaningful, and outputs are gated while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {s1_last, s1_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. The head entry is held until it is popped, so data and tlast
    // are stable while the sink stalls.
    // -------------------------------------------------------------------------
    assign head = mem[rd_ptr[ADDR_W-1:0]];

    // NOTE: every output of this combinational block gets a default first, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        m_tvalid = 1'b0;
        m_tdata  = '0;
        m_tlast  = 1'b0;
        if (!fifo_empty) begin
            m_tvalid = 1'b1;
            m_tdata  = head[63:0];
            m_tlast  = head[64];
        end
    end

    // row_done reflects the downstream handshake on the tlast word, delayed
    // by one register so it never forms a combinational path from m_tready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_done <= 1'b0;
        end else begin
            row_done <= pop & m_tlast;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rmsnorm_result_packer.sv
`timescale 1ns/1ps

module tb_rmsnorm_result_packer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         stage_start = 1'b0;
    logic         in_tvalid = 1'b0;
    logic [127:0] in_tdata = '0;
    logic         m_tready = 1'b0;
    logic         m_tvalid;
    logic [63:0]  m_tdata;
    logic         m_tlast;
    logic         overflow;
    logic         row_done;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;

    always #5 clk = ~clk;

    rmsnorm_result_packer #(
        .DATA_NUM   (192),
        .FIFO_DEPTH (16),
        .ADDR_W     (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stage_start (stage_start),
        .in_tvalid   (in_tvalid),
        .in_tdata    (in_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tlast     (m_tlast),
        .overflow    (overflow),
        .row_done    (row_done)
    );

    // Advance to just after the next rising edge: inputs change and outputs
    // are sampled here, away from the active edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Lanes whose low 16 bits are zero convert exactly: the bf16 equals the top half.
    function automatic logic [127:0] beat(input logic [15:0] v);
        return {v, 16'h0000, v, 16'h0000, v, 16'h0000, v, 16'h0000};
    endfunction

    function automatic logic [63:0] word(input logic [15:0] v);
        return {v, v, v, v};
    endfunction

    // {m_tvalid, m_tlast, m_tdata}
    function automatic logic [65:0] head_exp(input logic last, input logic [15:0] v);
        return {1'b1, last, word(v)};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) tick;
        check("rst_head", {m_tvalid, m_tlast, m_tdata}, 66'd0);
        check("rst_overflow", 66'(overflow), 66'd0);
        check("rst_row_done", 66'(row_done), 66'd0);
        rst_n = 1'b1;
        tick;

        // ---------------- T2 rounding + latency ----------------
        in_tvalid = 1'b1;
        in_tdata  = {32'h7F80_0001, 32'h3F81_8000, 32'h3F80_8000, 32'h4049_0FDB};
        tick;
        in_tvalid = 1'b0;
        check("t2_not_yet_valid", 66'(m_tvalid), 66'd0);
        tick;
        check("t2_rne_word", {m_tvalid, m_tlast, m_tdata}, {2'b10, 64'h7FC0_3F82_3F80_4049});

        // ---------------- T2b inf carry, -inf, denormal, -0 ----------------
        in_tvalid = 1'b1;
        in_tdata  = {32'h8000_0000, 32'h0000_0001, 32'hFF80_0000, 32'h7F7F_FFFF};
        tick;
        in_tvalid = 1'b0;
        tick;
        check("t2_head_stable", {m_tvalid, m_tlast, m_tdata}, {2'b10, 64'h7FC0_3F82_3F80_4049});
        m_tready = 1'b1;
        tick;
        check("t2b_inf_word", {m_tvalid, m_tlast, m_tdata}, {2'b10, 64'h8000_0000_FF80_7F80});
        tick;
        check("t2_drained", 66'(m_tvalid), 66'd0);
        m_tready = 1'b0;

        // clear so the row counter restarts at 0
        stage_start = 1'b1;
        tick;
        stage_start = 1'b0;

        // ---------------- T3 framing, 384 beats back-to-back ----------------
        m_tready = 1'b1;
        rd_cnt   = 0;
        for (int i = 0; i < 384; i++) begin
            in_tvalid = 1'b1;
            in_tdata  = beat(16'(i));
            tick;
            rd_cnt += int'(row_done);
            if (i >= 1) begin
                check($sformatf("t3_word%0d", i - 1), {m_tvalid, m_tlast, m_tdata},
                      head_exp((i - 1 == 191) || (i - 1 == 383), 16'(i - 1)));
            end
        end
        in_tvalid = 1'b0;
        tick;
        rd_cnt += int'(row_done);
        check("t3_word383", {m_tvalid, m_tlast, m_tdata}, head_exp(1'b1, 16'd383));
        tick;
        rd_cnt += int'(row_done);
        check("t3_empty", 66'(m_tvalid), 66'd0);
        tick;
        rd_cnt += int'(row_done);
        check("t3_row_done_count", 66'(rd_cnt), 66'd2);
        check("t3_no_overflow", 66'(overflow), 66'd0);

        // ---------------- T4 backpressure + overflow ----------------
        m_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_tvalid = 1'b1;
            in_tdata  = beat(16'(16'h0100 + i));
            tick;
            if (i == 2) begin
                check("t4_head_early", {m_tvalid, m_tlast, m_tdata}, head_exp(1'b0, 16'h0100));
            end
        end
        in_tvalid = 1'b0;
        tick;
        check("t4_overflow_set", 66'(overflow), 66'd1);
        check("t4_head_stable", {m_tvalid, m_tlast, m_tdata}, head_exp(1'b0, 16'h0100));
        m_tready = 1'b1;
        for (int k = 1; k < 16; k++) begin
            tick;
            check($sformatf("t4_drain%0d", k), {m_tvalid, m_tlast, m_tdata},
                  head_exp(1'b0, 16'(16'h0100 + k)));
        end
        tick;
        check("t4_beat16_dropped", 66'(m_tvalid), 66'd0);
        check("t4_overflow_sticky", 66'(overflow), 66'd1);

        // clear drops the sticky overflow
        stage_start = 1'b1;
        tick;
        stage_start = 1'b0;
        check("clear_overflow", 66'(overflow), 66'd0);

        // ---------------- T5 full FIFO with concurrent pop ----------------
        m_tready = 1'b0;
        for (int i = 0; i < 67; i++) begin
            in_tvalid = 1'b1;
            in_tdata  = beat(16'(16'h0200 + i));
            m_tready  = (i >= 17);
            tick;
            if (i >= 16) begin
                check($sformatf("t5_head%0d", i - 16), {m_tvalid, m_tlast, m_tdata},
                      head_exp(1'b0, 16'(16'h0200 + i - 16)));
            end
        end
        in_tvalid = 1'b0;
        check("t5_no_overflow", 66'(overflow), 66'd0);
        repeat (20) tick;
        check("t5_drained", 66'(m_tvalid), 66'd0);

        // ---------------- T1 reset mid-traffic with FIFO full ----------------
        m_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_tvalid = 1'b1;
            in_tdata  = beat(16'(16'h0300 + i));
            tick;
        end
        check("t1_pre_valid", 66'(m_tvalid), 66'd1);
        check("t1_pre_overflow", 66'(overflow), 66'd1);
        rst_n = 1'b0;
        #1;
        check("t1_async_head", {m_tvalid, m_tlast, m_tdata}, 66'd0);
        check("t1_async_overflow", 66'(overflow), 66'd0);
        check("t1_async_row_done", 66'(row_done), 66'd0);
        tick;
        in_tvalid = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;

        // ---------------- T6 clear mid-row ----------------
        m_tready = 1'b0;
        for (int i = 0; i < 101; i++) begin
            in_tvalid = 1'b1;
            in_tdata  = beat(16'(16'h0400 + i));
            tick;
        end
        check("t6_pre_overflow", 66'(overflow), 66'd1);
        // input beat in the clear cycle must be ignored
        stage_start = 1'b1;
        in_tvalid   = 1'b1;
        in_tdata    = beat(16'h0EAD);
        tick;
        check("t6_cleared_empty", 66'(m_tvalid), 66'd0);
        check("t6_cleared_overflow", 66'(overflow), 66'd0);
        m_tready = 1'b1;
        rd_cnt   = 0;
        for (int i = 0; i < 192; i++) begin
            in_tvalid = 1'b1;
            in_tdata  = beat(16'(16'h0500 + i));
            tick;
            rd_cnt += int'(row_done);
            if (i >= 1) begin
                check($sformatf("t6_word%0d", i - 1), {m_tvalid, m_tlast, m_tdata},
                      head_exp(1'b0, 16'(16'h0500 + i - 1)));
            end
        end
        in_tvalid = 1'b0;
        tick;
        rd_cnt += int'(row_done);
        check("t6_word191", {m_tvalid, m_tlast, m_tdata}, head_exp(1'b1, 16'h05BF));
        tick;
        rd_cnt += int'(row_done);
        tick;
        rd_cnt += int'(row_done);
        check("t6_row_done_count", 66'(rd_cnt), 66'd1);
        stage_start = 1'b0;
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
